// File: rtl/ray_box_slab_unit.sv
// Iterative ray/AABB slab test: per-axis reciprocal, slab multiply, min/max reduce.
// Optional RIB_TMAX_EN adds i_tmax, an upper clamp on t_exit captured with the ray.
module ray_box_slab_unit #(
   parameter int W        = 32,
   parameter int FRA_BITS = 16
) (
   input  logic                      i_clk,
   input  logic                      i_rst,
   input  logic                      i_valid,
   output logic                      o_ready,
   input  logic [1:0][2:0][W-1:0]    i_ray,
   input  logic [1:0][2:0][W-1:0]    i_box,
`ifdef RIB_TMAX_EN
   input  logic [W-1:0]              i_tmax,
`endif
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic                      o_hit,
   output logic [W-1:0]              o_t_entry,
   output logic [W-1:0]              o_t_exit
);

   localparam int CW = $clog2(W);
   localparam int PW = 2 * W + 2;
   localparam logic signed [W-1:0] FIP_MIN = {1'b1, {(W-1){1'b0}}};
   localparam logic signed [W-1:0] FIP_MAX = {1'b0, {(W-1){1'b1}}};
   // Dividend bits that sit above the W quotient bits produced by the loop.
   localparam logic [W:0] DIV_HI =
      (2 * FRA_BITS >= W) ? ((W+1)'(1) << (2 * FRA_BITS - W)) : '0;

   typedef enum logic [2:0] {
      IDLE,
      DIV,
      MUL,
      CMP,
      DONE
   } state_t;

   state_t state, state_n;

   logic signed [W-1:0] org  [3];
   logic signed [W-1:0] dir  [3];
   logic signed [W-1:0] bmin [3];
   logic signed [W-1:0] bmax [3];
   logic [W-1:0]        absd [3];
   logic [W-1:0]        rem  [3];
   logic [W-1:0]        quo  [3];
   logic [2:0]          sat;
   logic [CW-1:0]       cnt;
   logic signed [W-1:0] ta   [3];
   logic signed [W-1:0] tb   [3];
   logic                miss;
`ifdef RIB_TMAX_EN
   logic signed [W-1:0] tmax;
`endif

   logic [W-1:0]        abs_in [3];
   logic                bit_in;
   logic signed [W-1:0] ent, ext;
   logic                hit_n;

   function automatic logic signed [W-1:0] slab(
      input logic signed [W-1:0] c,
      input logic signed [W-1:0] e,
      input logic [W-1:0]        q,
      input logic                neg
   );
      logic signed [W:0]    d;
      logic signed [PW-1:0] p;
      d = {c[W-1], c} - {e[W-1], e};
      p = PW'(d) * $signed(PW'(q));
      p = p >>> FRA_BITS;
      if (neg)
         p = -p;
      if (p > PW'(FIP_MAX))
         slab = FIP_MAX;
      else if (p < PW'(FIP_MIN))
         slab = FIP_MIN;
      else
         slab = p[W-1:0];
   endfunction

   always_ff @(posedge i_clk) begin
      if (i_rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      o_ready = 1'b0;
      unique case (state)
         IDLE: begin
            o_ready = 1'b1;
            if (i_valid)
               state_n = DIV;
         end
         DIV:  if (cnt == '0) state_n = MUL;
         MUL:  state_n = CMP;
         CMP:  state_n = DONE;
         DONE: if (i_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      for (int k = 0; k < 3; k++)
         abs_in[k] = i_ray[1][k][W-1] ? W'(-i_ray[1][k]) : i_ray[1][k];
      bit_in = (32'(cnt) == 2 * FRA_BITS);
   end

   always_comb begin
      ent = FIP_MIN;
      ext = FIP_MAX;
      for (int k = 0; k < 3; k++) begin
         if ((ta[k] < tb[k] ? ta[k] : tb[k]) > ent)
            ent = ta[k] < tb[k] ? ta[k] : tb[k];
         if ((ta[k] > tb[k] ? ta[k] : tb[k]) < ext)
            ext = ta[k] > tb[k] ? ta[k] : tb[k];
      end
`ifdef RIB_TMAX_EN
      if (tmax < ext)
         ext = tmax;
`endif
      hit_n = !miss && (ext >= ent) && (ext >= 0);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int k = 0; k < 3; k++) begin
            org[k]  <= '0;
            dir[k]  <= '0;
            bmin[k] <= '0;
            bmax[k] <= '0;
            absd[k] <= '0;
            rem[k]  <= '0;
            quo[k]  <= '0;
            ta[k]   <= '0;
            tb[k]   <= '0;
         end
         sat       <= '0;
         cnt       <= '0;
         miss      <= 1'b0;
`ifdef RIB_TMAX_EN
         tmax      <= '0;
`endif
         o_valid   <= 1'b0;
         o_hit     <= 1'b0;
         o_t_entry <= '0;
         o_t_exit  <= '0;
      end else begin
         case (state)
            IDLE: if (i_valid) begin
               for (int k = 0; k < 3; k++) begin
                  org[k]  <= i_ray[0][k];
                  dir[k]  <= i_ray[1][k];
                  bmin[k] <= i_box[0][k];
                  bmax[k] <= i_box[1][k];
                  absd[k] <= abs_in[k];
                  rem[k]  <= DIV_HI[W-1:0];
                  quo[k]  <= '0;
                  sat[k]  <= (abs_in[k] != '0) && ({1'b0, abs_in[k]} <= DIV_HI);
               end
               cnt <= CW'(W - 1);
`ifdef RIB_TMAX_EN
               tmax <= i_tmax;
`endif
            end
            DIV: begin
               // Restoring step: one quotient bit per axis per cycle.
               for (int k = 0; k < 3; k++) begin
                  if (absd[k] != '0) begin
                     if ({rem[k], bit_in} >= {1'b0, absd[k]}) begin
                        rem[k] <= W'({rem[k], bit_in} - {1'b0, absd[k]});
                        quo[k] <= {quo[k][W-2:0], 1'b1};
                     end else begin
                        rem[k] <= {rem[k][W-2:0], bit_in};
                        quo[k] <= {quo[k][W-2:0], 1'b0};
                     end
                  end
               end
               cnt <= cnt - 1'b1;
            end
            MUL: begin
               miss <= 1'b0;
               for (int k = 0; k < 3; k++) begin
                  if (dir[k] == '0) begin
                     ta[k] <= FIP_MIN;
                     tb[k] <= FIP_MAX;
                     if (org[k] < bmin[k] || org[k] > bmax[k])
                        miss <= 1'b1;
                  end else begin
                     ta[k] <= slab(bmin[k], org[k],
                                   (sat[k] | quo[k][W-1]) ? FIP_MAX : quo[k],
                                   dir[k][W-1]);
                     tb[k] <= slab(bmax[k], org[k],
                                   (sat[k] | quo[k][W-1]) ? FIP_MAX : quo[k],
                                   dir[k][W-1]);
                  end
               end
            end
            CMP: begin
               o_hit     <= hit_n;
               o_t_entry <= ent[W-1] ? '0 : ent;
               o_t_exit  <= ext;
               o_valid   <= 1'b1;
            end
            DONE: if (i_ready) o_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule
